rs_div_station: RTL and testbench

Reservation station for the divide/remainder unit. It sits directly downstream of the RS/EX dispatch decoder and accepts every instruction the decoder steers to the div path (DIV, REM). It holds up to DEPTH entries and captures missing source operands from the common data bus (CDB). It issues the oldest entry whose operands are both ready to the divider through a valid/ready handshake.

---
 rtl/rs_div_station.sv | 197 +++++++++++++++++++
 tb/tb_rs_div_station.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_div_station.sv
//------------------------------------------------------------------------------
// rs_div_station : reservation station feeding the divide/remainder unit
// Revision       : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rs_div_station #(
  parameter int DEPTH = 4,
  parameter int IDXW  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            div_rs_on,
  input  logic [31:0]     in_operand1,
  input  logic [31:0]     in_operand2,
  input  logic [7:0]      in_op1_phy,
  input  logic [7:0]      in_op2_phy,
  input  logic [1:0]      in_valid,
  input  logic [2:0]      in_func3,
  input  logic [7:0]      in_rd_phy,
  input  logic [31:0]     in_inst_num,
  input  logic            cdb_valid,
  input  logic [7:0]      cdb_phy,
  input  logic [31:0]     cdb_data,
  input  logic            flush,
  input  logic            issue_ready,
  output logic            issue_valid,
  output logic [31:0]     issue_operand1,
  output logic [31:0]     issue_operand2,
  output logic [2:0]      issue_func3,
  output logic [7:0]      issue_rd_phy,
  output logic [31:0]     issue_inst_num,
  output logic            rs_full,
  output logic [IDXW:0]   rs_count
);

  localparam logic [IDXW:0] C_DEPTH = (IDXW+1)'(DEPTH);

  // Entry storage
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] r_rdy1;
  logic [DEPTH-1:0] r_rdy2;
  logic [31:0]      r_val1  [DEPTH];
  logic [31:0]      r_val2  [DEPTH];
  logic [7:0]       r_tag1  [DEPTH];
  logic [7:0]       r_tag2  [DEPTH];
  logic [2:0]       r_func3 [DEPTH];
  logic [7:0]       r_rd    [DEPTH];
  logic [31:0]      r_inst  [DEPTH];

  // Issue register
  logic             r_issue_valid;
  logic [31:0]      r_issue_op1;
  logic [31:0]      r_issue_op2;
  logic [2:0]       r_issue_func3;
  logic [7:0]       r_issue_rd;
  logic [31:0]      r_issue_inst;

  logic [DEPTH-1:0] w_elig;
  logic [DEPTH-1:0] w_wake1;
  logic [DEPTH-1:0] w_wake2;
  logic             w_sel_found;
  logic [IDXW-1:0]  w_sel_idx;
  logic [31:0]      w_sel_inst;
  logic             w_free_found;
  logic [IDXW-1:0]  w_free_idx;
  logic [IDXW:0]    w_count;
  logic             w_full;
  logic             w_load;
  logic             w_alloc;
  logic             w_byp1;
  logic             w_byp2;

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      assign w_elig[g]  = r_busy[g] & r_rdy1[g] & r_rdy2[g];
      assign w_wake1[g] = cdb_valid & r_busy[g] & ~r_rdy1[g] & (r_tag1[g] == cdb_phy);
      assign w_wake2[g] = cdb_valid & r_busy[g] & ~r_rdy2[g] & (r_tag2[g] == cdb_phy);
    end
  endgenerate

  // Oldest eligible entry; strict compare keeps the lowest index on ties
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    w_sel_inst  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_elig[i] && (!w_sel_found || (r_inst[i] < w_sel_inst))) begin
        w_sel_found = 1'b1;
        w_sel_idx   = IDXW'(i);
        w_sel_inst  = r_inst[i];
      end
    end
  end

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!r_busy[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = IDXW'(i);
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_count = w_count + (IDXW+1)'(r_busy[i]);
    end
  end

  assign w_full  = (w_count == C_DEPTH);
  assign w_load  = ~r_issue_valid | issue_ready;
  assign w_alloc = div_rs_on & ~w_full & w_free_found;
  assign w_byp1  = cdb_valid & ~in_valid[1] & (in_op1_phy == cdb_phy);
  assign w_byp2  = cdb_valid & ~in_valid[0] & (in_op2_phy == cdb_phy);

  // Wakeup touches only busy entries and allocation only a free one, while
  // the issued entry is always busy and ready, so the three never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy        <= '0;
      r_rdy1        <= '0;
      r_rdy2        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_val1[i]  <= '0;
        r_val2[i]  <= '0;
        r_tag1[i]  <= '0;
        r_tag2[i]  <= '0;
        r_func3[i] <= '0;
        r_rd[i]    <= '0;
        r_inst[i]  <= '0;
      end
      r_issue_valid <= 1'b0;
      r_issue_op1   <= '0;
      r_issue_op2   <= '0;
      r_issue_func3 <= '0;
      r_issue_rd    <= '0;
      r_issue_inst  <= '0;
    end else if (flush) begin
      r_busy        <= '0;
      r_issue_valid <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wake1[i]) begin
          r_val1[i] <= cdb_data;
          r_rdy1[i] <= 1'b1;
        end
        if (w_wake2[i]) begin
          r_val2[i] <= cdb_data;
          r_rdy2[i] <= 1'b1;
        end
      end

      if (w_alloc) begin
        r_busy[w_free_idx]  <= 1'b1;
        r_val1[w_free_idx]  <= w_byp1 ? cdb_data : in_operand1;
        r_val2[w_free_idx]  <= w_byp2 ? cdb_data : in_operand2;
        r_rdy1[w_free_idx]  <= in_valid[1] | w_byp1;
        r_rdy2[w_free_idx]  <= in_valid[0] | w_byp2;
        r_tag1[w_free_idx]  <= in_op1_phy;
        r_tag2[w_free_idx]  <= in_op2_phy;
        r_func3[w_free_idx] <= in_func3;
        r_rd[w_free_idx]    <= in_rd_phy;
        r_inst[w_free_idx]  <= in_inst_num;
      end

      if (w_load) begin
        if (w_sel_found) begin
          r_issue_valid     <= 1'b1;
          r_issue_op1       <= r_val1[w_sel_idx];
          r_issue_op2       <= r_val2[w_sel_idx];
          r_issue_func3     <= r_func3[w_sel_idx];
          r_issue_rd        <= r_rd[w_sel_idx];
          r_issue_inst      <= r_inst[w_sel_idx];
          r_busy[w_sel_idx] <= 1'b0;
        end else begin
          r_issue_valid <= 1'b0;
        end
      end
    end
  end

  assign issue_valid    = r_issue_valid;
  assign issue_operand1 = r_issue_op1;
  assign issue_operand2 = r_issue_op2;
  assign issue_func3    = r_issue_func3;
  assign issue_rd_phy   = r_issue_rd;
  assign issue_inst_num = r_issue_inst;
  assign rs_full        = w_full;
  assign rs_count       = w_count;

endmodule

`default_nettype wire

// File: tb/tb_rs_div_station.sv
//------------------------------------------------------------------------------
// tb_rs_div_station : directed self-checking bench for rs_div_station
// Revision          : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rs_div_station;

  logic        clk;
  logic        reset;
  logic        div_rs_on;
  logic [31:0] in_operand1;
  logic [31:0] in_operand2;
  logic [7:0]  in_op1_phy;
  logic [7:0]  in_op2_phy;
  logic [1:0]  in_valid;
  logic [2:0]  in_func3;
  logic [7:0]  in_rd_phy;
  logic [31:0] in_inst_num;
  logic        cdb_valid;
  logic [7:0]  cdb_phy;
  logic [31:0] cdb_data;
  logic        flush;
  logic        issue_ready;
  logic        issue_valid;
  logic [31:0] issue_operand1;
  logic [31:0] issue_operand2;
  logic [2:0]  issue_func3;
  logic [7:0]  issue_rd_phy;
  logic [31:0] issue_inst_num;
  logic        rs_full;
  logic [2:0]  rs_count;

  int errors = 0;
  int checks = 0;

  rs_div_station #(.DEPTH(4), .IDXW(2)) dut (
    .clk(clk), .reset(reset), .div_rs_on(div_rs_on),
    .in_operand1(in_operand1), .in_operand2(in_operand2),
    .in_op1_phy(in_op1_phy), .in_op2_phy(in_op2_phy),
    .in_valid(in_valid), .in_func3(in_func3), .in_rd_phy(in_rd_phy),
    .in_inst_num(in_inst_num), .cdb_valid(cdb_valid), .cdb_phy(cdb_phy),
    .cdb_data(cdb_data), .flush(flush), .issue_ready(issue_ready),
    .issue_valid(issue_valid), .issue_operand1(issue_operand1),
    .issue_operand2(issue_operand2), .issue_func3(issue_func3),
    .issue_rd_phy(issue_rd_phy), .issue_inst_num(issue_inst_num),
    .rs_full(rs_full), .rs_count(rs_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [2:0] f3, input logic [1:0] vld,
                       input logic [31:0] op1, input logic [31:0] op2,
                       input logic [7:0] t1, input logic [7:0] t2,
                       input logic [7:0] rd, input logic [31:0] inst);
    div_rs_on   = 1'b1;
    in_func3    = f3;
    in_valid    = vld;
    in_operand1 = op1;
    in_operand2 = op2;
    in_op1_phy  = t1;
    in_op2_phy  = t2;
    in_rd_phy   = rd;
    in_inst_num = inst;
  endtask

  task automatic cdb(input logic [7:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_phy   = tag;
    cdb_data  = data;
  endtask

  task automatic idle();
    div_rs_on = 1'b0;
    cdb_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); issue_ready = 1'b0;
    in_operand1 = '0; in_operand2 = '0; in_op1_phy = '0; in_op2_phy = '0;
    in_valid = '0; in_func3 = '0; in_rd_phy = '0; in_inst_num = '0;
    cdb_phy = '0; cdb_data = '0;
    step(); step();
    reset = 1'b0;
    checks++; if (rs_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", rs_count); end
    checks++; if (rs_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", rs_full); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", issue_valid); end
    checks++; if ({issue_operand1, issue_operand2, issue_func3, issue_rd_phy, issue_inst_num} !== 107'd0) begin
      errors++; $display("FAIL reset_data: got %0h expected 0", {issue_operand1, issue_operand2, issue_func3, issue_rd_phy, issue_inst_num}); end
  endtask

  task automatic test_basic_div();
    alloc(3'b100, 2'b11, 32'd100, 32'd7, 8'h01, 8'h02, 8'h21, 32'd5);
    step(); idle();
    checks++; if (rs_count !== 3'd1 || issue_valid !== 1'b0) begin errors++; $display("FAIL div_alloc: got count=%0d valid=%0b expected 1/0", rs_count, issue_valid); end
    step();
    checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL div_issue_valid: got %0b expected 1", issue_valid); end
    checks++; if (issue_operand1 !== 32'd100 || issue_operand2 !== 32'd7) begin errors++; $display("FAIL div_operands: got %0d/%0d expected 100/7", issue_operand1, issue_operand2); end
    checks++; if (issue_func3 !== 3'b100 || issue_rd_phy !== 8'h21 || issue_inst_num !== 32'd5) begin
      errors++; $display("FAIL div_fields: got f3=%0b rd=%0h inst=%0d expected 100/21/5", issue_func3, issue_rd_phy, issue_inst_num); end
    checks++; if (rs_count !== 3'd0) begin errors++; $display("FAIL div_count: got %0d expected 0", rs_count); end
    issue_ready = 1'b1;
    step();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL div_drain: got %0b expected 0", issue_valid); end
  endtask

  task automatic test_wakeup();
    alloc(3'b110, 2'b10, 32'd50, 32'hDEAD, 8'h10, 8'h33, 8'h22, 32'd6);
    step(); idle();
    step();
    checks++; if (rs_count !== 3'd1 || issue_valid !== 1'b0) begin errors++; $display("FAIL wake_wait: got count=%0d valid=%0b expected 1/0", rs_count, issue_valid); end
    cdb(8'h33, 32'd3);
    step(); idle();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_latency: got %0b expected 0", issue_valid); end
    step();
    checks++; if (issue_valid !== 1'b1 || issue_operand2 !== 32'd3 || issue_operand1 !== 32'd50 || issue_func3 !== 3'b110) begin
      errors++; $display("FAIL wake_issue: got v=%0b op1=%0d op2=%0d f3=%0b expected 1/50/3/110", issue_valid, issue_operand1, issue_operand2, issue_func3); end
    step();
    checks++; if (issue_valid !== 1'b0 || rs_count !== 3'd0) begin errors++; $display("FAIL wake_drain: got v=%0b count=%0d expected 0/0", issue_valid, rs_count); end
  endtask

  task automatic test_bypass();
    alloc(3'b100, 2'b00, 32'hBAD1, 32'hBAD2, 8'h70, 8'h71, 8'h23, 32'd7);
    cdb(8'h71, 32'd8);
    step(); idle();
    cdb(8'h70, 32'd64);
    step(); idle();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL bypass_early: got %0b expected 0", issue_valid); end
    step();
    checks++; if (issue_valid !== 1'b1 || issue_operand1 !== 32'd64 || issue_operand2 !== 32'd8) begin
      errors++; $display("FAIL bypass_issue: got v=%0b op1=%0d op2=%0d expected 1/64/8", issue_valid, issue_operand1, issue_operand2); end
    step();
  endtask

  task automatic test_age_order();
    issue_ready = 1'b0;
    alloc(3'b100, 2'b11, 32'd11, 32'd1, 8'h01, 8'h02, 8'h30, 32'd1);
    step();
    alloc(3'b100, 2'b00, 32'd0, 32'd0, 8'h40, 8'h40, 8'h31, 32'd9);
    step();
    alloc(3'b100, 2'b11, 32'd40, 32'd5, 8'h01, 8'h02, 8'h32, 32'd4);
    step();
    alloc(3'b110, 2'b11, 32'd20, 32'd3, 8'h01, 8'h02, 8'h33, 32'd2);
    step(); idle();
    checks++; if (issue_inst_num !== 32'd1 || rs_count !== 3'd3) begin errors++; $display("FAIL age_setup: got inst=%0d count=%0d expected 1/3", issue_inst_num, rs_count); end
    issue_ready = 1'b1;
    step();
    checks++; if (issue_valid !== 1'b1 || issue_inst_num !== 32'd2 || issue_operand1 !== 32'd20) begin
      errors++; $display("FAIL age_first: got v=%0b inst=%0d op1=%0d expected 1/2/20", issue_valid, issue_inst_num, issue_operand1); end
    step();
    checks++; if (issue_valid !== 1'b1 || issue_inst_num !== 32'd4 || issue_operand1 !== 32'd40) begin
      errors++; $display("FAIL age_second: got v=%0b inst=%0d op1=%0d expected 1/4/40", issue_valid, issue_inst_num, issue_operand1); end
    step();
    checks++; if (issue_valid !== 1'b0 || rs_count !== 3'd1) begin errors++; $display("FAIL age_blocked: got v=%0b count=%0d expected 0/1", issue_valid, rs_count); end
    cdb(8'h40, 32'd96);
    step(); idle();
    step();
    checks++; if (issue_valid !== 1'b1 || issue_inst_num !== 32'd9 || issue_operand1 !== 32'd96 || issue_operand2 !== 32'd96) begin
      errors++; $display("FAIL age_wake_both: got v=%0b inst=%0d op=%0d/%0d expected 1/9/96/96", issue_valid, issue_inst_num, issue_operand1, issue_operand2); end
    step();
  endtask

  task automatic test_full();
    issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alloc(3'b100, 2'b10, 32'd1, 32'd0, 8'h01, 8'h50 + 8'(i), 8'h40 + 8'(i), 32'd20 + 32'(i));
      step();
    end
    idle();
    checks++; if (rs_count !== 3'd4 || rs_full !== 1'b1) begin errors++; $display("FAIL full_set: got count=%0d full=%0b expected 4/1", rs_count, rs_full); end
    alloc(3'b100, 2'b11, 32'd240, 32'd24, 8'h01, 8'h02, 8'h48, 32'd24);
    step(); idle();
    checks++; if (rs_count !== 3'd4) begin errors++; $display("FAIL full_ignore: got count=%0d expected 4", rs_count); end
    step();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL full_no_issue: got %0b expected 0", issue_valid); end
    cdb(8'h52, 32'd9);
    step(); idle();
    step();
    checks++; if (issue_valid !== 1'b1 || issue_inst_num !== 32'd22 || issue_operand2 !== 32'd9) begin
      errors++; $display("FAIL full_wake_issue: got v=%0b inst=%0d op2=%0d expected 1/22/9", issue_valid, issue_inst_num, issue_operand2); end
    checks++; if (rs_count !== 3'd3 || rs_full !== 1'b0) begin errors++; $display("FAIL full_release: got count=%0d full=%0b expected 3/0", rs_count, rs_full); end
    alloc(3'b100, 2'b11, 32'd250, 32'd25, 8'h01, 8'h02, 8'h49, 32'd25);
    step(); idle();
    checks++; if (rs_count !== 3'd4 || rs_full !== 1'b1 || issue_valid !== 1'b0) begin
      errors++; $display("FAIL full_realloc: got count=%0d full=%0b v=%0b expected 4/1/0", rs_count, rs_full, issue_valid); end
    step();
    checks++; if (issue_valid !== 1'b1 || issue_inst_num !== 32'd25 || rs_count !== 3'd3) begin
      errors++; $display("FAIL full_new_issue: got v=%0b inst=%0d count=%0d expected 1/25/3", issue_valid, issue_inst_num, rs_count); end
    flush = 1'b1;
    step(); idle();
    checks++; if (rs_count !== 3'd0 || issue_valid !== 1'b0) begin errors++; $display("FAIL full_flush: got count=%0d v=%0b expected 0/0", rs_count, issue_valid); end
  endtask

  task automatic test_hold();
    issue_ready = 1'b0;
    alloc(3'b100, 2'b11, 32'd300, 32'd30, 8'h01, 8'h02, 8'h60, 32'd30);
    step();
    alloc(3'b110, 2'b11, 32'd310, 32'd31, 8'h01, 8'h02, 8'h61, 32'd31);
    step(); idle();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (issue_valid !== 1'b1 || issue_inst_num !== 32'd30 || issue_operand1 !== 32'd300 || issue_rd_phy !== 8'h60 || rs_count !== 3'd1) begin
        errors++; $display("FAIL hold_cycle%0d: got v=%0b inst=%0d op1=%0d rd=%0h count=%0d expected 1/30/300/60/1",
                            i, issue_valid, issue_inst_num, issue_operand1, issue_rd_phy, rs_count); end
      step();
    end
    issue_ready = 1'b1;
    step();
    checks++; if (issue_valid !== 1'b1 || issue_inst_num !== 32'd31 || issue_operand1 !== 32'd310 || issue_func3 !== 3'b110) begin
      errors++; $display("FAIL hold_release: got v=%0b inst=%0d op1=%0d f3=%0b expected 1/31/310/110", issue_valid, issue_inst_num, issue_operand1, issue_func3); end
    step();
    checks++; if (issue_valid !== 1'b0 || rs_count !== 3'd0) begin errors++; $display("FAIL hold_drain: got v=%0b count=%0d expected 0/0", issue_valid, rs_count); end
  endtask

  task automatic fill_four();
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alloc(3'b100, 2'b11, 32'd400 + 32'(i), 32'd4, 8'h01, 8'h02, 8'h70, 32'd40 + 32'(i));
      step();
    end
    idle();
  endtask

  task automatic test_flush_reset();
    fill_four();
    checks++; if (rs_count !== 3'd3 || issue_valid !== 1'b1 || issue_inst_num !== 32'd40) begin
      errors++; $display("FAIL flush_setup: got count=%0d v=%0b inst=%0d expected 3/1/40", rs_count, issue_valid, issue_inst_num); end
    flush = 1'b1;
    alloc(3'b100, 2'b11, 32'd440, 32'd4, 8'h01, 8'h02, 8'h71, 32'd44);
    cdb(8'h01, 32'd1);
    step(); idle();
    checks++; if (rs_count !== 3'd0 || issue_valid !== 1'b0 || rs_full !== 1'b0) begin
      errors++; $display("FAIL flush_result: got count=%0d v=%0b full=%0b expected 0/0/0", rs_count, issue_valid, rs_full); end
    step();
    checks++; if (issue_valid !== 1'b0 || rs_count !== 3'd0) begin errors++; $display("FAIL flush_ignored_alloc: got v=%0b count=%0d expected 0/0", issue_valid, rs_count); end
    fill_four();
    reset = 1'b1;
    alloc(3'b100, 2'b11, 32'd440, 32'd4, 8'h01, 8'h02, 8'h71, 32'd44);
    cdb(8'h01, 32'd1);
    step(); idle();
    reset = 1'b0;
    checks++; if (rs_count !== 3'd0 || issue_valid !== 1'b0 || rs_full !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got count=%0d v=%0b full=%0b expected 0/0/0", rs_count, issue_valid, rs_full); end
    checks++; if (issue_operand1 !== 32'd0 || issue_inst_num !== 32'd0) begin
      errors++; $display("FAIL reset_mid_data: got op1=%0d inst=%0d expected 0/0", issue_operand1, issue_inst_num); end
    step();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_quiet: got %0b expected 0", issue_valid); end
  endtask

  initial begin
    test_reset();
    test_basic_div();
    test_wakeup();
    test_bypass();
    test_age_order();
    test_full();
    test_hold();
    test_flush_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
